// File: rtl/word_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_aligner_if
//  Description : Serial-in / aligned-word-out bundle for word_aligner.
//                err_cnt is present only when WORD_ALIGNER_ERR_CNT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_aligner_if;
    logic        data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        sync_err;
`ifdef WORD_ALIGNER_ERR_CNT_EN
    logic [15:0] err_cnt;

    modport master (output data_in, input data_out, data_valid, locked, sync_err, err_cnt);
    modport slave  (input data_in, output data_out, data_valid, locked, sync_err, err_cnt);
`else
    modport master (output data_in, input data_out, data_valid, locked, sync_err);
    modport slave  (input data_in, output data_out, data_valid, locked, sync_err);
`endif
endinterface
`default_nettype wire

// File: rtl/word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : word_aligner
//  Description : Serial frame aligner. Hunts for SYNC_WORD on a 1-bit line,
//                verifies LOCK_CNT consecutive syncs, then emits each of the
//                FRAME_WORDS payload words per frame as 32-bit words.
//                Optional macro WORD_ALIGNER_ERR_CNT_EN adds a saturating
//                16-bit sync-error counter (err_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module word_aligner #(
    parameter logic [31:0] SYNC_WORD   = 32'hA5C3_3C5A,
    parameter int          FRAME_WORDS = 4,
    parameter int          LOCK_CNT    = 3,
    parameter int          UNLOCK_CNT  = 2
) (
    input  wire           clk,
    input  wire           rst,
    word_aligner_if.slave bus
);

    localparam logic [7:0] c_LAST_SLOT = 8'(FRAME_WORDS);
    localparam logic [3:0] c_LOCK      = 4'(LOCK_CNT);
    localparam logic [3:0] c_UNLOCK    = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_sh;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_slot_cnt, w_slot_nxt;
    logic [3:0]  r_good, w_good_nxt;
    logic [3:0]  r_bad, w_bad_nxt;
    logic [31:0] r_data_out;
    logic        r_valid, r_locked, r_sync_err;

    logic [31:0] w_word;
    logic        w_match, w_boundary, w_sync_slot;
    logic        w_emit, w_err, w_to_hunt;

    // The candidate word includes the bit being sampled this cycle.
    assign w_word      = {r_sh[30:0], bus.data_in};
    assign w_match     = (w_word == SYNC_WORD);
    assign w_boundary  = (r_bit_cnt == 5'd31);
    assign w_sync_slot = (r_slot_cnt == 8'd0);

    // Next-state and counter update; a HUNT entry clears all frame counters.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_slot_nxt    = r_slot_cnt;
        w_good_nxt    = r_good;
        w_bad_nxt     = r_bad;
        w_emit        = 1'b0;
        w_err         = 1'b0;
        w_to_hunt     = 1'b0;

        if (r_state != S_HUNT) begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
            if (w_boundary) begin
                w_slot_nxt = (r_slot_cnt == c_LAST_SLOT) ? 8'd0 : r_slot_cnt + 8'd1;
            end
        end

        case (r_state)
            S_HUNT: begin
                if (w_match) begin
                    w_state_nxt   = S_VERIFY;
                    w_bit_cnt_nxt = 5'd0;
                    w_slot_nxt    = 8'd1;
                    w_good_nxt    = 4'd1;
                    w_bad_nxt     = 4'd0;
                end
            end
            S_VERIFY: begin
                if (w_boundary && w_sync_slot) begin
                    if (w_match) begin
                        w_good_nxt = r_good + 4'd1;
                        if ((r_good + 4'd1) >= c_LOCK) begin
                            w_state_nxt = S_LOCKED;
                            w_bad_nxt   = 4'd0;
                        end
                    end else begin
                        w_err     = 1'b1;
                        w_to_hunt = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (w_boundary) begin
                    if (!w_sync_slot) begin
                        w_emit = 1'b1;
                    end else if (w_match) begin
                        w_bad_nxt = 4'd0;
                    end else begin
                        // Bad sync keeps alignment; only repeated misses drop lock.
                        w_err = 1'b1;
                        if ((r_bad + 4'd1) >= c_UNLOCK) begin
                            w_to_hunt = 1'b1;
                        end else begin
                            w_bad_nxt = r_bad + 4'd1;
                        end
                    end
                end
            end
            default: w_to_hunt = 1'b1;
        endcase

        if (w_to_hunt) begin
            w_state_nxt   = S_HUNT;
            w_bit_cnt_nxt = 5'd0;
            w_slot_nxt    = 8'd0;
            w_good_nxt    = 4'd0;
            w_bad_nxt     = 4'd0;
        end
    end

    // State and frame-position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HUNT;
            r_bit_cnt  <= 5'd0;
            r_slot_cnt <= 8'd0;
            r_good     <= 4'd0;
            r_bad      <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_slot_cnt <= w_slot_nxt;
            r_good     <= w_good_nxt;
            r_bad      <= w_bad_nxt;
        end
    end

    // Line shift register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= 32'd0;
        end else begin
            r_sh <= w_word;
        end
    end

    // Registered outputs: strobes last one cycle, data_out holds between words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= 32'd0;
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_valid    <= w_emit;
            r_sync_err <= w_err;
            r_locked   <= (w_state_nxt == S_LOCKED);
            if (w_emit) begin
                r_data_out <= w_word;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_valid;
    assign bus.locked     = r_locked;
    assign bus.sync_err   = r_sync_err;

`ifdef WORD_ALIGNER_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of sync errors, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/word_aligner.md
WORD_ALIGNER -- requirements
Module: word_aligner

Interface
REQ-001 Parameter SYNC_WORD, default 32'hA5C3_3C5A: frame sync pattern, MSB first on the line.
REQ-002 Parameter FRAME_WORDS, default 4: payload words following each sync word (range 1..255).
REQ-003 Parameter LOCK_CNT, default 3: consecutive good syncs needed to declare lock (1..15).
REQ-004 Parameter UNLOCK_CNT, default 2: consecutive bad syncs needed to drop lock (1..15).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  1  serial line bit, one bit sampled per clk.
REQ-008 data_out  output  32  aligned payload word.
REQ-009 data_valid  output  1  one-cycle strobe qualifying data_out.
REQ-010 locked  output  1  high while in LOCKED state.
REQ-011 sync_err  output  1  one-cycle strobe on each mismatched sync slot while VERIFY/LOCKED.
REQ-012 err_cnt  output  16  sync-error counter; present only with the configuration macro defined.

Function
REQ-013 Shift register shall update every clk: sh <= {sh[30:0], data_in}; candidate word W = {sh[30:0], data_in}.
REQ-014 FSM states HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-015 HUNT: W compared every cycle; on W == SYNC_WORD go VERIFY, bit_cnt <= 0, slot_cnt <= 1 (first payload slot), good_cnt <= 1.
REQ-016 bit_cnt (5 bits) shall increment every cycle outside HUNT; word boundary when bit_cnt == 31, wrapping to 0.
REQ-017 slot_cnt shall advance at each word boundary, 0 = sync slot, 1..FRAME_WORDS = payload, wrapping FRAME_WORDS -> 0.
REQ-018 VERIFY: at sync-slot boundary, W == SYNC_WORD increments good_cnt; reaching LOCK_CNT goes LOCKED; mismatch asserts sync_err and returns to HUNT.
REQ-019 VERIFY with LOCK_CNT == 1 shall enter LOCKED at the first boundary of a sync slot that matches; payload is never output in VERIFY.
REQ-020 LOCKED: at payload-slot boundary, data_out <= W and data_valid pulses high for exactly the following cycle (latency 1 clk after the word's last bit is sampled).
REQ-021 LOCKED: sync-slot match clears bad_cnt; mismatch asserts sync_err, increments bad_cnt, keeps current alignment and outputs nothing for that slot.
REQ-022 LOCKED: bad_cnt reaching UNLOCK_CNT shall go HUNT on that same edge; following payload words are not output.
REQ-023 Entering HUNT from any state shall clear good_cnt, bad_cnt, bit_cnt, slot_cnt; sh is never cleared except by rst.
REQ-024 locked shall be registered: high the cycle after the LOCKED transition edge, low the cycle after leaving.
REQ-025 data_out shall hold its last value when data_valid is low.

Reset
REQ-026 rst high shall asynchronously force state HUNT, sh = 0, all counters 0, data_out = 0, data_valid = 0, locked = 0, sync_err = 0, err_cnt = 0.
REQ-027 rst asserted mid-frame shall discard the partial word; after release alignment restarts from HUNT with no output until relock.
REQ-028 rst is released synchronously to clk by the integrating level.

Configuration
REQ-029 Macro WORD_ALIGNER_ERR_CNT_EN: defined -> err_cnt port exists, increments on each sync_err pulse, saturates at 16'hFFFF, cleared only by rst.
REQ-030 Undefined -> err_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-031 Random 17 bits, then 3 frames (sync + 4 words 0x1..0x4) -> locked rises 1 clk after 3rd sync boundary; 4 data_valid strobes 0x1..0x4 follow.
REQ-032 Locked stream, one sync corrupted to 0xA5C33C5B -> single sync_err, locked stays 1, payload of that frame still output; err_cnt = 1 with macro.
REQ-033 Locked stream, two consecutive corrupted syncs -> locked falls 1 clk after 2nd bad boundary, no further data_valid until 3 good frames.
REQ-034 VERIFY after 1 good sync, then bad sync -> sync_err pulse, state HUNT, locked never asserted.
REQ-035 rst pulsed mid-payload word while locked -> all outputs 0 immediately; relock after 3 frames with correct words.
REQ-036 LOCK_CNT=1, FRAME_WORDS=1: sync + 0xDEADBEEF repeated -> locked after 2nd sync, data_out 0xDEADBEEF every 64 clks.
